// File: rtl/pe_row_pkg.sv
// rtl/pe_row_pkg.sv - shared constants, FSM state type and saturating add for pe_row_sched
package pe_row_pkg;

    localparam int LEN_MAX  = 64;
    localparam int GRP_MAX  = 16;
    localparam int PIPE_LAT = 3;
    localparam int RES_W    = 9;
    localparam int ACC_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WREQ   = 3'd1,
        ST_WLOAD  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    // Operands are sign-extended to 32 bits by the caller; result clamps to a w-bit signed range.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        s  = a + b;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/pe_row_tagpipe.sv
// rtl/pe_row_tagpipe.sv - shift register of {valid, pos, last_grp} matching the PE row latency
module pe_row_tagpipe
    import pe_row_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT,
    parameter int POS_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [POS_W-1:0] in_pos,
    input  logic             in_last,
    output logic             out_valid,
    output logic [POS_W-1:0] out_pos,
    output logic             out_last,
    output logic             any_valid
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] last_q;
    logic [POS_W-1:0] pos_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= in_valid;
            last_q[0] <= in_last;
            pos_q[0]  <= in_pos;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
                pos_q[i]  <= pos_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_pos   = pos_q[DEPTH-1];
    assign out_last  = last_q[DEPTH-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/pe_row_sched.sv
// rtl/pe_row_sched.sv - sequences one PE row through groups x positions and accumulates psums
module pe_row_sched
    import pe_row_pkg::*;
#(
    parameter int LEN_MAX  = pe_row_pkg::LEN_MAX,
    parameter int GRP_MAX  = pe_row_pkg::GRP_MAX,
    parameter int PIPE_LAT = pe_row_pkg::PIPE_LAT,
    parameter int RES_W    = pe_row_pkg::RES_W,
    parameter int ACC_W    = pe_row_pkg::ACC_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [$clog2(LEN_MAX+1)-1:0]   cfg_len,
    input  logic [$clog2(GRP_MAX+1)-1:0]   cfg_groups,
    output logic                           busy,
    output logic                           done,
    output logic                           w_req,
    output logic [$clog2(GRP_MAX)-1:0]     w_grp,
    input  logic                           w_ack,
    output logic                           new_weight_val,
    input  logic                           slide_valid,
    output logic                           slide_en,
    output logic [$clog2(LEN_MAX)-1:0]     slide_pos,
    input  logic                           row_out_val,
    input  logic signed [RES_W-1:0]        row_result,
    output logic                           out_valid,
    output logic [$clog2(LEN_MAX)-1:0]     out_idx,
    output logic signed [ACC_W-1:0]        out_data
);

    localparam int LEN_W  = $clog2(LEN_MAX + 1);
    localparam int GCNT_W = $clog2(GRP_MAX + 1);
    localparam int GRP_W  = $clog2(GRP_MAX);
    localparam int POS_W  = $clog2(LEN_MAX);

    state_e state_q;
    state_e state_d;

    logic [LEN_W-1:0]  len_q;
    logic [GCNT_W-1:0] groups_q;
    logic [GRP_W-1:0]  grp_q;
    logic [POS_W-1:0]  pos_q;
    logic [LEN_W-1:0]  len_clamp;
    logic [GCNT_W-1:0] groups_clamp;
    logic              last_pos;
    logic              last_grp;
    logic              cfg_empty;

    logic              tag_valid;
    logic [POS_W-1:0]  tag_pos;
    logic              tag_last;
    logic              pipe_busy;

    logic signed [ACC_W-1:0] psum [LEN_MAX];
    logic signed [31:0]      acc_ext;
    logic signed [31:0]      row_ext;
    logic signed [ACC_W-1:0] sum;

    always_comb begin
        len_clamp    = (cfg_len > LEN_W'(LEN_MAX)) ? LEN_W'(LEN_MAX) : cfg_len;
        groups_clamp = (cfg_groups > GCNT_W'(GRP_MAX)) ? GCNT_W'(GRP_MAX) : cfg_groups;
        cfg_empty    = (cfg_len == '0) || (cfg_groups == '0);
        last_pos     = (LEN_W'(pos_q) == len_q - LEN_W'(1));
        last_grp     = (GCNT_W'(grp_q) == groups_q - GCNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = cfg_empty ? ST_FIN : ST_WREQ;
                end
            end
            ST_WREQ: begin
                if (w_ack) begin
                    state_d = ST_WLOAD;
                end
            end
            ST_WLOAD: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (slide_valid && last_pos) begin
                    state_d = ST_DRAIN;
                end
            end
            // Weights may only change once every in-flight tag has retired.
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_d = last_grp ? ST_FIN : ST_WREQ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy           = (state_q != ST_IDLE) && (state_q != ST_FIN);
        done           = (state_q == ST_FIN);
        w_req          = (state_q == ST_WREQ);
        new_weight_val = (state_q == ST_WLOAD);
        slide_en       = (state_q == ST_STREAM) && slide_valid;
        slide_pos      = pos_q;
        w_grp          = grp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            groups_q <= '0;
            grp_q    <= '0;
            pos_q    <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                len_q    <= len_clamp;
                groups_q <= groups_clamp;
                grp_q    <= '0;
            end
            if (state_q == ST_WLOAD) begin
                pos_q <= '0;
            end else if (slide_en && !last_pos) begin
                pos_q <= pos_q + POS_W'(1);
            end
            if ((state_q == ST_DRAIN) && !pipe_busy && !last_grp) begin
                grp_q <= grp_q + GRP_W'(1);
            end
        end
    end

    pe_row_tagpipe #(
        .DEPTH (PIPE_LAT),
        .POS_W (POS_W)
    ) u_tagpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (slide_en),
        .in_pos    (pos_q),
        .in_last   (last_grp),
        .out_valid (tag_valid),
        .out_pos   (tag_pos),
        .out_last  (tag_last),
        .any_valid (pipe_busy)
    );

    // An unprimed row contributes nothing to the running sum.
    always_comb begin
        acc_ext = 32'(psum[tag_pos]);
        row_ext = row_out_val ? 32'(row_result) : 32'sd0;
        sum     = ACC_W'(sat_add(acc_ext, row_ext, ACC_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN_MAX; i++) begin
                psum[i] <= '0;
            end
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (tag_valid) begin
                if (tag_last) begin
                    psum[tag_pos] <= '0;
                    out_valid     <= 1'b1;
                    out_idx       <= tag_pos;
                    out_data      <= sum;
                end else begin
                    psum[tag_pos] <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_row_sched.sv
// tb/tb_pe_row_sched.sv - scoreboard bench for pe_row_sched built with a 12-bit accumulator
module tb_pe_row_sched;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [6:0]        cfg_len = '0;
    logic [4:0]        cfg_groups = '0;
    logic              busy;
    logic              done;
    logic              w_req;
    logic [3:0]        w_grp;
    logic              w_ack = 1'b0;
    logic              new_weight_val;
    logic              slide_valid = 1'b0;
    logic              slide_en;
    logic [5:0]        slide_pos;
    logic              row_out_val = 1'b1;
    logic signed [8:0] row_result = '0;
    logic              out_valid;
    logic [5:0]        out_idx;
    logic signed [11:0] out_data;

    int checks = 0;
    int passed = 0;

    int res_tab [64];
    bit sv_pat [$];
    int exp_idx_q [$];
    int exp_data_q [$];
    int obs_idx_q [$];
    int obs_data_q [$];
    int grp_log [$];
    int spos_log [$];

    int cyc = 0, start_cyc = 0, done_cyc = 0, out_cyc = 0;
    int done_cnt = 0, wreq_cnt = 0, nwv_cnt = 0, se_cnt = 0, out_cnt = 0;
    int sidx = 1000;
    bit wreq_prev = 1'b0;
    bit h0_v = 0, h1_v = 0, h2_v = 0;
    int h0_p = 0, h1_p = 0, h2_p = 0;

    always #5 clk = ~clk;

    pe_row_sched #(.ACC_W(12)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_len        (cfg_len),
        .cfg_groups     (cfg_groups),
        .busy           (busy),
        .done           (done),
        .w_req          (w_req),
        .w_grp          (w_grp),
        .w_ack          (w_ack),
        .new_weight_val (new_weight_val),
        .slide_valid    (slide_valid),
        .slide_en       (slide_en),
        .slide_pos      (slide_pos),
        .row_out_val    (row_out_val),
        .row_result     (row_result),
        .out_valid      (out_valid),
        .out_idx        (out_idx),
        .out_data       (out_data)
    );

    // Monitor on the falling edge; weight bus, slide buffer and 3-cycle PE row model just after the rising edge.
    always begin
        @(negedge clk);
        cyc++;
        if (start) start_cyc = cyc;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (w_req && !wreq_prev) wreq_cnt++;
        wreq_prev = w_req;
        if (new_weight_val) begin nwv_cnt++; grp_log.push_back(int'(w_grp)); sidx = 0; end
        if (slide_en) begin se_cnt++; spos_log.push_back(int'(slide_pos)); end
        if (out_valid) begin
            out_cnt++;
            out_cyc = cyc;
            obs_idx_q.push_back(int'(out_idx));
            obs_data_q.push_back(int'(out_data));
        end
        h2_v = h1_v; h2_p = h1_p;
        h1_v = h0_v; h1_p = h0_p;
        h0_v = slide_en; h0_p = int'(slide_pos);
        @(posedge clk);
        #1;
        w_ack = w_req;
        slide_valid = (sidx < sv_pat.size()) ? sv_pat[sidx] : 1'b1;
        sidx++;
        row_result = h2_v ? 9'(res_tab[h2_p]) : 9'sd77;
    end

    task automatic start_pass(input int len, input int grp);
        @(posedge clk);
        #2;
        start = 1'b1;
        cfg_len = 7'(len);
        cfg_groups = 5'(grp);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, w_req, new_weight_val, slide_en, out_valid, w_grp, slide_pos, out_idx, out_data} !== '0)
            $display("FAIL reset_outputs got busy=%b done=%b w_req=%b nwv=%b se=%b ov=%b out_data=%0d required all zero",
                     busy, done, w_req, new_weight_val, slide_en, out_valid, out_data);
        else passed++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_group();
        int n0, o0;
        bit ok;
        res_tab[0] = 5; res_tab[1] = -3; res_tab[2] = 0; res_tab[3] = 255;
        for (int p = 0; p < 4; p++) begin exp_idx_q.push_back(p); exp_data_q.push_back(res_tab[p]); end
        n0 = nwv_cnt; o0 = out_cnt;
        start_pass(4, 1);
        wait_done(300, ok);
        checks++;
        if (!ok) $display("FAIL single_done timeout got no done required done"); else passed++;
        checks++;
        if (nwv_cnt - n0 !== 1) $display("FAIL single_nwv got %0d pulses required 1", nwv_cnt - n0); else passed++;
        checks++;
        if (out_cnt - o0 !== 4) $display("FAIL single_outcount got %0d required 4", out_cnt - o0); else passed++;
        checks++;
        if (!(done_cyc > out_cyc && done_cyc <= out_cyc + 2))
            $display("FAIL single_done_timing got done cycle %0d last out cycle %0d required done 1-2 cycles after", done_cyc, out_cyc);
        else passed++;
        while (exp_idx_q.size() > 0) begin
            int ei, ed, oi, od;
            ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
            oi = (obs_idx_q.size() > 0) ? obs_idx_q.pop_front() : -1;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : -99999;
            checks++;
            if (oi !== ei || od !== ed) $display("FAIL single_sb got idx %0d data %0d required idx %0d data %0d", oi, od, ei, ed);
            else passed++;
        end
    endtask

    task automatic test_accumulate();
        int w0, n0, o0;
        bit ok;
        res_tab[0] = 100; res_tab[1] = 100;
        for (int p = 0; p < 2; p++) begin exp_idx_q.push_back(p); exp_data_q.push_back(300); end
        w0 = wreq_cnt; n0 = nwv_cnt; o0 = out_cnt;
        grp_log.delete();
        start_pass(2, 3);
        wait_done(300, ok);
        checks++;
        if (!ok) $display("FAIL accum_done timeout got no done required done"); else passed++;
        checks++;
        if (wreq_cnt - w0 !== 3 || nwv_cnt - n0 !== 3)
            $display("FAIL accum_handshakes got w_req %0d nwv %0d required 3 and 3", wreq_cnt - w0, nwv_cnt - n0);
        else passed++;
        for (int g = 0; g < 3; g++) begin
            int gv;
            gv = (grp_log.size() > 0) ? grp_log.pop_front() : -1;
            checks++;
            if (gv !== g) $display("FAIL accum_w_grp got %0d required %0d", gv, g); else passed++;
        end
        checks++;
        if (out_cnt - o0 !== 2) $display("FAIL accum_outcount got %0d required 2", out_cnt - o0); else passed++;
        while (exp_idx_q.size() > 0) begin
            int ei, ed, oi, od;
            ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
            oi = (obs_idx_q.size() > 0) ? obs_idx_q.pop_front() : -1;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : -99999;
            checks++;
            if (oi !== ei || od !== ed) $display("FAIL accum_sb got idx %0d data %0d required idx %0d data %0d", oi, od, ei, ed);
            else passed++;
        end
    endtask

    task automatic test_stall();
        int s0, o0;
        bit ok;
        res_tab[0] = 10; res_tab[1] = 20; res_tab[2] = 30;
        for (int p = 0; p < 3; p++) begin exp_idx_q.push_back(p); exp_data_q.push_back(res_tab[p]); end
        sv_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        spos_log.delete();
        s0 = se_cnt; o0 = out_cnt;
        start_pass(3, 1);
        wait_done(300, ok);
        sv_pat.delete();
        checks++;
        if (!ok) $display("FAIL stall_done timeout got no done required done"); else passed++;
        checks++;
        if (se_cnt - s0 !== 3) $display("FAIL stall_se_count got %0d required 3", se_cnt - s0); else passed++;
        for (int p = 0; p < 3; p++) begin
            int sp;
            sp = (spos_log.size() > 0) ? spos_log.pop_front() : -1;
            checks++;
            if (sp !== p) $display("FAIL stall_slide_pos got %0d required %0d", sp, p); else passed++;
        end
        checks++;
        if (out_cnt - o0 !== 3) $display("FAIL stall_outcount got %0d required 3", out_cnt - o0); else passed++;
        while (exp_idx_q.size() > 0) begin
            int ei, ed, oi, od;
            ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
            oi = (obs_idx_q.size() > 0) ? obs_idx_q.pop_front() : -1;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : -99999;
            checks++;
            if (oi !== ei || od !== ed) $display("FAIL stall_sb got idx %0d data %0d required idx %0d data %0d", oi, od, ei, ed);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        int vals [2];
        int n0;
        bit ok;
        vals[0] = 255; vals[1] = -256;
        for (int k = 0; k < 2; k++) begin
            int acc;
            acc = 0;
            for (int g = 0; g < 16; g++) begin
                acc = acc + vals[k];
                if (acc > 2047) acc = 2047;
                if (acc < -2048) acc = -2048;
            end
            res_tab[0] = vals[k];
            exp_idx_q.push_back(0); exp_data_q.push_back(acc);
            n0 = nwv_cnt;
            start_pass(1, (k == 0) ? 16 : 20);
            wait_done(1000, ok);
            checks++;
            if (!ok || nwv_cnt - n0 !== 16)
                $display("FAIL sat_groups done=%0d got %0d weight loads required 16", ok, nwv_cnt - n0);
            else passed++;
        end
        while (exp_idx_q.size() > 0) begin
            int ei, ed, oi, od;
            ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
            oi = (obs_idx_q.size() > 0) ? obs_idx_q.pop_front() : -1;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : -99999;
            checks++;
            if (oi !== ei || od !== ed) $display("FAIL sat_sb got idx %0d data %0d required idx %0d data %0d", oi, od, ei, ed);
            else passed++;
        end
    endtask

    task automatic test_len_clamp();
        int o0, bad;
        bit ok;
        for (int p = 0; p < 64; p++) begin
            res_tab[p] = p * 3 - 90;
            exp_idx_q.push_back(p); exp_data_q.push_back(res_tab[p]);
        end
        o0 = out_cnt;
        start_pass(100, 1);
        wait_done(1000, ok);
        checks++;
        if (!ok || out_cnt - o0 !== 64) $display("FAIL clamp_len done=%0d got %0d outputs required 64", ok, out_cnt - o0);
        else passed++;
        bad = 0;
        while (exp_idx_q.size() > 0) begin
            int ei, ed, oi, od;
            ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
            oi = (obs_idx_q.size() > 0) ? obs_idx_q.pop_front() : -1;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : -99999;
            checks++;
            if (oi !== ei || od !== ed) $display("FAIL clamp_sb got idx %0d data %0d required idx %0d data %0d", oi, od, ei, ed);
            else passed++;
        end
    endtask

    task automatic test_zero_and_busy();
        int w0, s0, o0, d0, n0;
        bit ok;
        w0 = wreq_cnt; s0 = se_cnt; o0 = out_cnt;
        start_pass(0, 2);
        wait_done(20, ok);
        checks++;
        if (!ok || done_cyc - start_cyc > 2)
            $display("FAIL zero_done done=%0d got latency %0d required at most 2", ok, done_cyc - start_cyc);
        else passed++;
        checks++;
        if (wreq_cnt - w0 !== 0 || se_cnt - s0 !== 0 || out_cnt - o0 !== 0)
            $display("FAIL zero_activity got w_req %0d slide_en %0d out %0d required 0 0 0", wreq_cnt - w0, se_cnt - s0, out_cnt - o0);
        else passed++;
        res_tab[0] = 1; res_tab[1] = 2;
        exp_idx_q.push_back(0); exp_data_q.push_back(1);
        exp_idx_q.push_back(1); exp_data_q.push_back(2);
        o0 = out_cnt; d0 = done_cnt; n0 = nwv_cnt;
        start_pass(2, 1);
        repeat (3) @(posedge clk);
        start_pass(5, 3);
        wait_done(300, ok);
        repeat (40) @(posedge clk);
        checks++;
        if (!ok || done_cnt - d0 !== 1 || nwv_cnt - n0 !== 1 || out_cnt - o0 !== 2)
            $display("FAIL busy_start got done %0d nwv %0d out %0d required 1 1 2", done_cnt - d0, nwv_cnt - n0, out_cnt - o0);
        else passed++;
        while (exp_idx_q.size() > 0) begin
            int ei, ed, oi, od;
            ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
            oi = (obs_idx_q.size() > 0) ? obs_idx_q.pop_front() : -1;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : -99999;
            checks++;
            if (oi !== ei || od !== ed) $display("FAIL busy_sb got idx %0d data %0d required idx %0d data %0d", oi, od, ei, ed);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_stream();
        int o0;
        bit found, ok;
        for (int p = 0; p < 5; p++) res_tab[p] = 50;
        start_pass(5, 2);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (slide_en && slide_pos == 6'd2) begin
                found = 1'b1;
                break;
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!found || {busy, done, w_req, new_weight_val, slide_en, out_valid, w_grp, slide_pos, out_idx, out_data} !== '0)
            $display("FAIL reset_mid reached=%0d got busy=%b se=%b slide_pos=%0d ov=%b required all zero", found, busy, slide_en, slide_pos, out_valid);
        else passed++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        obs_idx_q.delete();
        obs_data_q.delete();
        for (int p = 0; p < 3; p++) begin
            res_tab[p] = 7;
            exp_idx_q.push_back(p); exp_data_q.push_back(7);
        end
        o0 = out_cnt;
        start_pass(3, 1);
        wait_done(300, ok);
        checks++;
        if (!ok || out_cnt - o0 !== 3) $display("FAIL reset_rerun done=%0d got %0d outputs required 3", ok, out_cnt - o0);
        else passed++;
        while (exp_idx_q.size() > 0) begin
            int ei, ed, oi, od;
            ei = exp_idx_q.pop_front(); ed = exp_data_q.pop_front();
            oi = (obs_idx_q.size() > 0) ? obs_idx_q.pop_front() : -1;
            od = (obs_data_q.size() > 0) ? obs_data_q.pop_front() : -99999;
            checks++;
            if (oi !== ei || od !== ed) $display("FAIL reset_sb got idx %0d data %0d required idx %0d data %0d", oi, od, ei, ed);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_accumulate();
        test_stall();
        test_saturation();
        test_len_clamp();
        test_zero_and_busy();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
